crc_engine_v2: RTL

//  Second-generation CRC accelerator peripheral for the TinyQV bus. Polynomial, init, xorout and

---
 rtl/crc_engine_v2.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/crc_engine_v2.sv
// CRC accelerator peripheral: runtime poly/init/xorout, BPC message bits per clock,
// small input FIFO whose head (or a fresh push) loads the shifter on the edge it drains.
module crc_engine_v2 #(
  parameter int CRC_W      = 32,
  parameter int BPC        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam logic [31:0] CRC_MASK = ~(32'hFFFF_FFFF >> CRC_W);
  localparam logic [5:0] STEP = 6'(BPC);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [31:0] crc_reg, crc_next, poly_reg, poly_next, xorout_reg, xorout_next;
  logic [31:0] sh_reg, sh_next, crc_step, sh_step;
  logic [5:0]  cnt_reg, cnt_next;
  logic        irq_en_reg, irq_en_next, ovf_reg, ovf_next, done_reg, done_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [5:0]  fifo_bits [FIFO_DEPTH];

  logic [3:0]  idx;
  logic        wr, rd, push, flush, busy, finishing, empty, full, idle, idle_next;
  logic        pop, direct, fifo_wr, drop, done_clr;
  logic [31:0] lane_mask, push_top, data_msb, data_rev, push_sh, wdata_crc;
  logic [31:0] final_val, final_rev, stat;
  logic [5:0]  push_bits;
  logic        unused_addr;

  assign idx         = address[5:2];
  assign unused_addr = ^address[1:0];
  assign wr          = data_write_n != 2'b11;
  assign rd          = data_read_n != 2'b11;
  assign push        = wr && (idx == 4'd2 || idx == 4'd3);
  assign flush       = wr && idx == 4'd0;

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    push_top  = 32'hFFFF_FFFF;
    push_bits = 6'd32;
    case (data_write_n)
      2'b00: begin lane_mask = 32'h0000_00FF; push_top = 32'hFF00_0000; push_bits = 6'd8; end
      2'b01: begin lane_mask = 32'h0000_FFFF; push_top = 32'hFFFF_0000; push_bits = 6'd16; end
      default: ;
    endcase
  end

  // DATA streams byte 0 first, each byte MSB-first; REFL streams bit 0 first.
  assign data_msb = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
      assign data_rev[gi]  = data_in[31-gi];
      assign final_rev[gi] = final_val[31-gi];
    end
  endgenerate
  assign push_sh   = ((idx == 4'd3) ? data_rev : data_msb) & push_top;
  assign wdata_crc = ((crc_reg & ~lane_mask) | (data_in & lane_mask)) & CRC_MASK;

  always_comb begin
    logic fb;
    fb       = 1'b0;
    crc_step = crc_reg;
    sh_step  = sh_reg;
    for (int i = 0; i < BPC; i++) begin
      fb       = crc_step[31] ^ sh_step[31];
      crc_step = {crc_step[30:0], 1'b0} ^ (fb ? poly_reg : 32'h0);
      sh_step  = {sh_step[30:0], 1'b0};
    end
  end

  assign busy      = cnt_reg != 6'd0;
  assign finishing = cnt_reg <= STEP;
  assign empty     = level_reg == '0;
  assign full      = level_reg == LVL_FULL;
  assign idle      = !busy && empty;
  assign pop       = finishing && !empty;
  // A push arriving as the shifter drains with nothing queued goes straight in.
  assign direct    = push && finishing && empty;
  assign fifo_wr   = push && !direct && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    crc_next    = busy ? crc_step : crc_reg;
    poly_next   = poly_reg;
    xorout_next = xorout_reg;
    irq_en_next = irq_en_reg;
    sh_next     = sh_reg;
    cnt_next    = cnt_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (busy) begin
      sh_next  = sh_step;
      cnt_next = cnt_reg - STEP;
    end
    if (flush) begin
      crc_next    = wdata_crc;
      cnt_next    = 6'd0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (pop) begin
        sh_next     = fifo_data[rd_ptr_reg];
        cnt_next    = fifo_bits[rd_ptr_reg];
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end else if (direct) begin
        sh_next  = push_sh;
        cnt_next = push_bits;
      end
      if (fifo_wr) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (fifo_wr && !pop) level_next = level_reg + LVL_W'(1);
      else if (!fifo_wr && pop) level_next = level_reg - LVL_W'(1);
    end
    if (wr && idx == 4'd1) poly_next = ((poly_reg & ~lane_mask) | (data_in & lane_mask)) & CRC_MASK;
    if (wr && idx == 4'd5) xorout_next = ((xorout_reg & ~lane_mask) | (data_in & lane_mask)) & CRC_MASK;
    if (wr && idx == 4'd8) irq_en_next = data_in[0];
  end

  // An abort via CRC load is not a completion, so it never raises done.
  assign idle_next = (cnt_next == 6'd0) && (level_next == '0);
  assign done_clr  = (wr && idx == 4'd4 && data_in[3]) || flush || (rd && (idx == 4'd6 || idx == 4'd7));
  assign done_next = (!idle && idle_next && !flush) || (done_reg && !done_clr);
  assign ovf_next  = drop || (ovf_reg && !(wr && idx == 4'd4 && data_in[2]));

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr_reg] <= push_sh;
      fifo_bits[wr_ptr_reg] <= push_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg    <= '0;
      poly_reg   <= '0;
      xorout_reg <= '0;
      irq_en_reg <= 1'b0;
      sh_reg     <= '0;
      cnt_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      crc_reg    <= crc_next;
      poly_reg   <= poly_next;
      xorout_reg <= xorout_next;
      irq_en_reg <= irq_en_next;
      sh_reg     <= sh_next;
      cnt_reg    <= cnt_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign final_val = crc_reg ^ xorout_reg;
  assign stat      = {24'h0, 4'(level_reg), done_reg, ovf_reg, full, idle};

  always_comb begin
    data_out = 32'h0;
    case (idx)
      4'd0, 4'd2, 4'd3: data_out = crc_reg;
      4'd1: data_out = poly_reg;
      4'd4: data_out = stat;
      4'd5: data_out = xorout_reg;
      4'd6: data_out = final_val;
      4'd7: data_out = final_rev;
      4'd8: data_out = {31'h0, irq_en_reg};
      default: data_out = 32'h0;
    endcase
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_en_reg & done_reg;
endmodule
